coredma_dsc_cache_ecc: RTL and testbench

Parametrised descriptor-cache RAM for the CoreDMA controller with real SECDED protection, replacing the fixed 128x128 wrapper whose error flags are tied low. It holds the descriptor array, encodes Hamming check bits on write, and decodes and corrects on a 2-cycle pipelined read. Single-bit correction and double-bit detection are reported per read, with saturating error counters and last-error address capture. It sits between the descriptor fetch engine (writer) and the channel arbiter (reader).

---
 rtl/coredma_dsc_cache_ecc_if.sv | 34 +++
 rtl/coredma_dsc_cache_ecc.sv | 173 +++++++++++++++++
 tb/tb_coredma_dsc_cache_ecc.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/coredma_dsc_cache_ecc_if.sv
// Descriptor-cache bus: write port, read port with valid beat, error status.
// master = fetch engine / arbiter side, slave = cache.
interface coredma_dsc_cache_ecc_if #(
   parameter int WIDTH      = 128,
   parameter int ADDR_WIDTH = 7,
   parameter int CNT_WIDTH  = 16
);
   logic                  WEN;
   logic [ADDR_WIDTH-1:0] WADDR;
   logic [WIDTH-1:0]      WDATA;
   logic [1:0]            ERR_INJ;
   logic                  REN;
   logic [ADDR_WIDTH-1:0] RADDR;
   logic [WIDTH-1:0]      RDATA;
   logic                  RVALID;
   logic                  SB_CORRECT;
   logic                  DB_DETECT;
   logic [CNT_WIDTH-1:0]  SB_COUNT;
   logic [CNT_WIDTH-1:0]  DB_COUNT;
   logic [ADDR_WIDTH-1:0] ERR_ADDR;
   logic                  CNT_CLR;

   modport master (
      output WEN, WADDR, WDATA, ERR_INJ, REN, RADDR, CNT_CLR,
      input  RDATA, RVALID, SB_CORRECT, DB_DETECT,
      input  SB_COUNT, DB_COUNT, ERR_ADDR
   );

   modport slave (
      input  WEN, WADDR, WDATA, ERR_INJ, REN, RADDR, CNT_CLR,
      output RDATA, RVALID, SB_CORRECT, DB_DETECT,
      output SB_COUNT, DB_COUNT, ERR_ADDR
   );
endinterface

// File: rtl/coredma_dsc_cache_ecc.sv
// SECDED-protected descriptor cache: Hamming encode on write, 2-cycle
// decode/correct read, per-beat SB/DB flags, saturating counters, ERR_ADDR.
module coredma_dsc_cache_ecc #(
   parameter int WIDTH      = 128,
   parameter int DEPTH      = 128,
   parameter int ADDR_WIDTH = 7,
   parameter bit ECC_EN     = 1'b1,
   parameter int CNT_WIDTH  = 16
) (
   input logic                    CLOCK,
   input logic                    RESET_N,
   coredma_dsc_cache_ecc_if.slave bus
);

   function automatic int calc_r(input int w);
      int r;
      r = 0;
      for (int i = 1; i < 32; i++)
         if (r == 0 && (1 << i) >= w + i + 1) r = i;
      return r;
   endfunction

   localparam int R  = calc_r(WIDTH);
   localparam int N  = WIDTH + R;
   // Stored word: bit 0 = overall parity, bits 1..N = Hamming positions.
   localparam int SW = ECC_EN ? N + 1 : WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

   logic                  wr_ok, rd_ok, byp, inj1, inj2;
   logic [SW-1:0]         wr_word, rd_word;
   logic [SW-1:0]         mem_q [DEPTH];
   logic                  s1_v_q, s1_ok_q;
   logic [ADDR_WIDTH-1:0] s1_addr_q;
   logic [SW-1:0]         s1_word_q;
   logic [WIDTH-1:0]      dec_data;
   logic                  dec_sb, dec_db;
   logic [WIDTH-1:0]      rdata_q;
   logic                  rvalid_q, sb_q, db_q;
   logic [ADDR_WIDTH-1:0] oaddr_q;
   logic [CNT_WIDTH-1:0]  sb_cnt_q, sb_cnt_d, db_cnt_q, db_cnt_d;
   logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

   assign wr_ok = bus.WEN && ({1'b0, bus.WADDR} < DEPTH_C);
   assign rd_ok = bus.REN && ({1'b0, bus.RADDR} < DEPTH_C);
   assign byp   = wr_ok && (bus.WADDR == bus.RADDR);
   assign inj1  = (bus.ERR_INJ == 2'b01) || (bus.ERR_INJ == 2'b10);
   assign inj2  = (bus.ERR_INJ == 2'b10);

   generate
      if (ECC_EN) begin : g_ecc
         always_comb begin : enc
            logic [N:0] c;
            int         j;
            c = '0;
            j = 0;
            for (int p = 1; p <= N; p++)
               if ((p & (p - 1)) != 0) begin
                  c[p] = bus.WDATA[j];
                  j++;
               end
            for (int i = 0; i < R; i++)
               for (int p = 1; p <= N; p++)
                  if (((p >> i) & 1) == 1 && p != (1 << i))
                     c[1 << i] = c[1 << i] ^ c[p];
            c[0] = ^c;
            // Data bits 0 and 1 live at Hamming positions 3 and 5.
            c[3] = c[3] ^ inj1;
            c[5] = c[5] ^ inj2;
            wr_word = c;
         end

         always_comb begin : dec
            logic [R-1:0] syn;
            logic         par;
            logic [N:0]   fx;
            logic [WIDTH-1:0] dd;
            int           k;
            syn = '0;
            for (int p = 1; p <= N; p++)
               if (s1_word_q[p]) syn = syn ^ R'(p);
            par = ^s1_word_q;
            fx  = s1_word_q;
            // Only a bad overall parity triggers a flip; a double error
            // therefore passes the raw data through.
            for (int p = 1; p <= N; p++)
               if (par && syn == R'(p)) fx[p] = ~fx[p];
            dd = '0;
            k  = 0;
            for (int p = 1; p <= N; p++)
               if ((p & (p - 1)) != 0) begin
                  dd[k] = fx[p];
                  k++;
               end
            dec_data = s1_ok_q ? dd : '0;
            dec_sb   = s1_ok_q && par;
            dec_db   = s1_ok_q && !par && (syn != '0);
         end
      end else begin : g_raw
         always_comb begin
            wr_word    = bus.WDATA;
            wr_word[0] = bus.WDATA[0] ^ inj1;
            wr_word[1] = bus.WDATA[1] ^ inj2;
            dec_data   = s1_ok_q ? s1_word_q : '0;
            dec_sb     = 1'b0;
            dec_db     = 1'b0;
         end
      end
   endgenerate

   assign rd_word = byp ? wr_word : mem_q[bus.RADDR];

   always_ff @(posedge CLOCK)
      if (wr_ok) mem_q[bus.WADDR] <= wr_word;

   always_comb begin
      sb_cnt_d   = sb_cnt_q;
      db_cnt_d   = db_cnt_q;
      err_addr_d = err_addr_q;
      if (bus.CNT_CLR) begin
         sb_cnt_d   = '0;
         db_cnt_d   = '0;
         err_addr_d = '0;
      end else begin
         if (sb_q) begin
            if (sb_cnt_q != '1) sb_cnt_d = sb_cnt_q + 1'b1;
            err_addr_d = oaddr_q;
         end
         if (db_q) begin
            if (db_cnt_q != '1) db_cnt_d = db_cnt_q + 1'b1;
            err_addr_d = oaddr_q;
         end
      end
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         s1_v_q     <= 1'b0;
         s1_ok_q    <= 1'b0;
         s1_addr_q  <= '0;
         s1_word_q  <= '0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
         sb_q       <= 1'b0;
         db_q       <= 1'b0;
         oaddr_q    <= '0;
         sb_cnt_q   <= '0;
         db_cnt_q   <= '0;
         err_addr_q <= '0;
      end else begin
         s1_v_q     <= bus.REN;
         s1_ok_q    <= rd_ok;
         s1_addr_q  <= bus.RADDR;
         s1_word_q  <= rd_ok ? rd_word : '0;
         rdata_q    <= dec_data;
         rvalid_q   <= s1_v_q;
         sb_q       <= dec_sb;
         db_q       <= dec_db;
         oaddr_q    <= s1_addr_q;
         sb_cnt_q   <= sb_cnt_d;
         db_cnt_q   <= db_cnt_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign bus.RDATA      = rdata_q;
   assign bus.RVALID     = rvalid_q;
   assign bus.SB_CORRECT = sb_q;
   assign bus.DB_DETECT  = db_q;
   assign bus.SB_COUNT   = sb_cnt_q;
   assign bus.DB_COUNT   = db_cnt_q;
   assign bus.ERR_ADDR   = err_addr_q;

endmodule

// File: tb/tb_coredma_dsc_cache_ecc.sv
// Bench for coredma_dsc_cache_ecc: directed scenarios plus random traffic
// against a behavioural model of stored data, injected faults and counters.
module tb_coredma_dsc_cache_ecc;
   localparam int W   = 128;
   localparam int D   = 100;
   localparam int AW  = 7;
   localparam int CW  = 4;
   localparam int SAT = 15;

   logic clk = 1'b0;
   logic rst_n;

   coredma_dsc_cache_ecc_if #(.WIDTH(W), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) ifc ();

   coredma_dsc_cache_ecc #(
      .WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .ECC_EN(1'b1), .CNT_WIDTH(CW)
   ) dut (
      .CLOCK(clk), .RESET_N(rst_n), .bus(ifc)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         due;
      int         a;
      logic [W-1:0] d;
      bit         sb;
      bit         db;
   } exp_t;

   int n_err = 0;
   int n_chk = 0;
   int cyc   = 0;
   logic [W-1:0] m_data [128];
   logic [1:0]   m_inj  [128];
   bit           m_wr   [128];
   exp_t q[$];
   int e_sb = 0, e_db = 0, e_addr = 0;
   bit lb_sb = 0, lb_db = 0;
   int lb_a = 0;

   task automatic chk(input string tag, input logic [W-1:0] got,
                      input logic [W-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic idle();
      ifc.WEN = 1'b0; ifc.WADDR = '0; ifc.WDATA = '0; ifc.ERR_INJ = 2'b00;
      ifc.REN = 1'b0; ifc.RADDR = '0; ifc.CNT_CLR = 1'b0;
   endtask

   task automatic check_beat();
      exp_t e;
      lb_sb = 0;
      lb_db = 0;
      if (q.size() != 0 && q[0].due == cyc) begin
         e = q.pop_front();
         chk("rvalid", W'(ifc.RVALID), W'(1));
         chk("rdata", ifc.RDATA, e.d);
         chk("sb_correct", W'(ifc.SB_CORRECT), W'(e.sb));
         chk("db_detect", W'(ifc.DB_DETECT), W'(e.db));
         lb_sb = e.sb;
         lb_db = e.db;
         lb_a  = e.a;
      end else begin
         chk("rvalid_idle", W'(ifc.RVALID), W'(0));
         chk("flags_idle", W'({ifc.SB_CORRECT, ifc.DB_DETECT}), W'(0));
      end
      chk("sb_count", W'(ifc.SB_COUNT), W'(e_sb));
      chk("db_count", W'(ifc.DB_COUNT), W'(e_db));
      chk("err_addr", W'(ifc.ERR_ADDR), W'(e_addr));
   endtask

   // Account for the inputs currently driven, then advance one clock.
   task automatic step();
      exp_t e;
      int   a;
      if (ifc.WEN && int'(ifc.WADDR) < D) begin
         m_data[ifc.WADDR] = ifc.WDATA;
         m_inj[ifc.WADDR]  = (ifc.ERR_INJ == 2'b11) ? 2'b00 : ifc.ERR_INJ;
         m_wr[ifc.WADDR]   = 1'b1;
      end
      if (ifc.REN) begin
         a     = int'(ifc.RADDR);
         e.due = cyc + 2;
         e.a   = a;
         if (a >= D) begin
            e.d = '0; e.sb = 0; e.db = 0;
         end else begin
            e.d  = m_data[a];
            e.sb = (m_inj[a] == 2'b01);
            e.db = (m_inj[a] == 2'b10);
            if (e.db) e.d = e.d ^ W'(3);
         end
         q.push_back(e);
      end
      if (ifc.CNT_CLR) begin
         e_sb = 0; e_db = 0; e_addr = 0;
      end else begin
         if (lb_sb) begin
            e_sb   = (e_sb < SAT) ? e_sb + 1 : SAT;
            e_addr = lb_a;
         end
         if (lb_db) begin
            e_db   = (e_db < SAT) ? e_db + 1 : SAT;
            e_addr = lb_a;
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_beat();
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_write(input int a, input logic [W-1:0] d,
                           input logic [1:0] inj);
      idle();
      ifc.WEN = 1'b1; ifc.WADDR = AW'(a); ifc.WDATA = d; ifc.ERR_INJ = inj;
      step();
      idle();
   endtask

   task automatic do_read(input int a);
      idle();
      ifc.REN = 1'b1; ifc.RADDR = AW'(a);
      step();
      idle();
   endtask

   initial begin
      int a;
      int seq[4];
      idle();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_rvalid", W'(ifc.RVALID), W'(0));
      chk("rst_rdata", ifc.RDATA, '0);
      chk("rst_flags", W'({ifc.SB_CORRECT, ifc.DB_DETECT}), W'(0));
      chk("rst_sb_count", W'(ifc.SB_COUNT), W'(0));
      chk("rst_db_count", W'(ifc.DB_COUNT), W'(0));
      chk("rst_err_addr", W'(ifc.ERR_ADDR), W'(0));
      rst_n = 1'b1;
      idle_n(2);

      do_write(5, 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF, 2'b00);
      do_read(5);
      idle_n(3);
      do_write(9, rnd128(), 2'b01);
      do_read(9);
      idle_n(3);
      do_write(3, rnd128(), 2'b10);
      do_read(3);
      idle_n(3);

      do_write(7, rnd128(), 2'b00);
      ifc.WEN = 1'b1; ifc.WADDR = AW'(7); ifc.WDATA = W'(16'h1234);
      ifc.REN = 1'b1; ifc.RADDR = AW'(7);
      step();
      idle();
      idle_n(3);

      seq = '{5, 9, 3, 7};
      for (int i = 0; i < 4; i++) begin
         ifc.REN = 1'b1; ifc.RADDR = AW'(seq[i]);
         step();
      end
      idle();
      idle_n(3);

      for (int i = 0; i < 20; i++) begin
         ifc.REN = 1'b1; ifc.RADDR = AW'(9);
         step();
      end
      idle();
      idle_n(3);
      chk("sb_saturated", W'(ifc.SB_COUNT), W'(SAT));

      // Clear lands on the same edge that would count this SB beat.
      do_read(9);
      step();
      ifc.CNT_CLR = 1'b1;
      step();
      idle();
      chk("clr_sb_count", W'(ifc.SB_COUNT), W'(0));
      idle_n(2);

      ifc.WEN = 1'b1; ifc.WADDR = AW'(120); ifc.WDATA = rnd128();
      ifc.REN = 1'b1; ifc.RADDR = AW'(120);
      step();
      idle();
      idle_n(3);

      do_read(3);
      idle_n(3);
      ifc.REN = 1'b1; ifc.RADDR = AW'(5);
      step();
      ifc.RADDR = AW'(9);
      #2 rst_n = 1'b0;
      idle();
      q.delete();
      e_sb = 0; e_db = 0; e_addr = 0; lb_sb = 0; lb_db = 0;
      #1;
      chk("inrst_rvalid", W'(ifc.RVALID), W'(0));
      chk("inrst_db_count", W'(ifc.DB_COUNT), W'(0));
      idle_n(3);
      rst_n = 1'b1;
      do_read(5);
      idle_n(3);

      for (int i = 0; i < 400; i++) begin
         ifc.WEN     = 1'($urandom_range(0, 1));
         ifc.WADDR   = AW'($urandom_range(0, 127));
         ifc.WDATA   = rnd128();
         ifc.ERR_INJ = 2'($urandom_range(0, 3));
         ifc.REN     = 1'($urandom_range(0, 1));
         a = $urandom_range(0, 127);
         if ($urandom_range(0, 3) == 0) a = int'(ifc.WADDR);
         ifc.RADDR = AW'(a);
         if (a < D && !m_wr[a] && !(ifc.WEN && int'(ifc.WADDR) == a))
            ifc.REN = 1'b0;
         ifc.CNT_CLR = ($urandom_range(0, 19) == 0);
         step();
         idle();
      end
      idle_n(4);
      chk("drain", W'(q.size()), W'(0));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
